// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state and redirect-source types for the fetch PC generator.
package pc_gen_pkg;
  typedef enum logic {RESET, RUN} state_t;
  typedef enum logic [1:0] {NONE, FLUSH, PEND, BRANCH} redir_t;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry valid+target holding register for deferred redirects.
module pc_redirect_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         consume,
  input  logic [W-1:0] load_target,
  output logic         valid,
  output logic [W-1:0] target
);
  // clear beats load so a flush can discard a same-cycle capture; load beats consume so the latest request survives
  always_ff @(posedge clk) begin
    valid  <= rst | clear ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : valid;
    target <= load ? load_target : target;
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with flush/branch redirects and a pending-branch buffer.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              fetch_ready_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_valid_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              fetch_valid_o,
  output logic              pend_o,
  output logic              misalign_o
);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);
  state_t state, state_next;
  redir_t src;
  logic run, adv, load, clear, consume;
  logic [ADDR_W-1:0] pend_target, raw, nxt;
  assign run = state == RUN;
  assign ce_o = run;
  assign fetch_valid_o = ce_o;
  assign adv = ce_o & ~stall_i & fetch_ready_i;
  assign clear = run & flush_valid_i;
  assign consume = src == PEND;
  // a branch that cannot be applied now, or arrives while an older one drains, is parked
  assign load = run & ~flush_valid_i & branch_valid_i & (~adv | pend_o);
  always_comb begin
    state_next = rst ? RESET : RUN;
    src = ~run ? NONE : flush_valid_i ? FLUSH : adv & pend_o ? PEND : adv & branch_valid_i ? BRANCH : NONE;
    raw = src == FLUSH ? flush_target_i : src == PEND ? pend_target : branch_target_i;
    nxt = src != NONE ? raw & ~MASK : adv ? pc_o + ADDR_W'(INST_BYTES) : pc_o;
  end
  always_ff @(posedge clk) begin
    state      <= state_next;
    pc_o       <= rst ? RESET_VEC : nxt;
    misalign_o <= ~rst & (src != NONE) & |(raw & MASK);
  end
  pc_redirect_buf #(.W(ADDR_W)) u_buf (
    .clk(clk),
    .rst(rst),
    .load(load),
    .clear(clear),
    .consume(consume),
    .load_target(branch_target_i),
    .valid(pend_o),
    .target(pend_target)
  );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (32-bit and 8-bit wrap instances).
module tb_pc_gen;
  logic clk = 0, rst = 1;
  logic stall = 0, ready = 1, br = 0, fl = 0;
  logic [31:0] br_t = 0, fl_t = 0, pc;
  logic ce, fv, pend, mis;
  logic stall8 = 0, ready8 = 1, br8 = 0;
  logic [7:0] br8_t = 0, pc8;
  logic ce8, fv8, pend8, mis8;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h100), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
    .branch_valid_i(br), .branch_target_i(br_t), .flush_valid_i(fl), .flush_target_i(fl_t),
    .pc_o(pc), .ce_o(ce), .fetch_valid_o(fv), .pend_o(pend), .misalign_o(mis)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'hFC), .INST_BYTES(4)) dut8 (
    .clk(clk), .rst(rst), .stall_i(stall8), .fetch_ready_i(ready8),
    .branch_valid_i(br8), .branch_target_i(br8_t), .flush_valid_i(1'b0), .flush_target_i(8'h00),
    .pc_o(pc8), .ce_o(ce8), .fetch_valid_o(fv8), .pend_o(pend8), .misalign_o(mis8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    total++; if (pc !== 32'h100) $display("FAIL reset_pc got %h want 00000100", pc); else passed++;
    total++; if ({ce, fv, pend, mis} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {ce, fv, pend, mis}); else passed++;
    rst = 0;
    step();
    total++; if (pc !== 32'h100 || ce !== 1'b1 || fv !== 1'b1) $display("FAIL first_fetch got pc=%h ce=%b fv=%b want 00000100 1 1", pc, ce, fv); else passed++;
    step();
    total++; if (pc !== 32'h104) $display("FAIL seq1 got %h want 00000104", pc); else passed++;
    step();
    total++; if (pc !== 32'h108) $display("FAIL seq2 got %h want 00000108", pc); else passed++;
  endtask

  task automatic test_branch();
    br = 1; br_t = 32'h200;
    step();
    br = 0;
    total++; if (pc !== 32'h200 || mis !== 1'b0) $display("FAIL branch got pc=%h mis=%b want 00000200 0", pc, mis); else passed++;
    step();
    total++; if (pc !== 32'h204) $display("FAIL branch_seq got %h want 00000204", pc); else passed++;
  endtask

  task automatic test_pending();
    stall = 1; br = 1; br_t = 32'h300;
    step();
    br = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if (pc !== 32'h204 || pend !== 1'b1) $display("FAIL pend_hold%0d got pc=%h pend=%b want 00000204 1", i, pc, pend); else passed++;
      if (i < 2) step();
    end
    stall = 0;
    step();
    total++; if (pc !== 32'h300 || pend !== 1'b0) $display("FAIL pend_apply got pc=%h pend=%b want 00000300 0", pc, pend); else passed++;
  endtask

  task automatic test_flush();
    stall = 1; ready = 0; br = 1; br_t = 32'h400;
    step();
    br = 0;
    total++; if (pend !== 1'b1 || pc !== 32'h300) $display("FAIL flush_setup got pc=%h pend=%b want 00000300 1", pc, pend); else passed++;
    fl = 1; fl_t = 32'h80;
    step();
    fl = 0;
    total++; if (pc !== 32'h80 || pend !== 1'b0) $display("FAIL flush got pc=%h pend=%b want 00000080 0", pc, pend); else passed++;
    stall = 0; ready = 1;
    step();
    total++; if (pc !== 32'h84) $display("FAIL flush_nofetch got %h want 00000084", pc); else passed++;
  endtask

  task automatic test_back_to_back();
    stall = 1; br = 1; br_t = 32'h500;
    step();
    stall = 0; br_t = 32'h600;
    step();
    br = 0;
    total++; if (pc !== 32'h500 || pend !== 1'b1) $display("FAIL b2b_first got pc=%h pend=%b want 00000500 1", pc, pend); else passed++;
    step();
    total++; if (pc !== 32'h600 || pend !== 1'b0) $display("FAIL b2b_second got pc=%h pend=%b want 00000600 0", pc, pend); else passed++;
    fl = 1; fl_t = 32'h40; br = 1; br_t = 32'h700;
    step();
    fl = 0; br = 0;
    total++; if (pc !== 32'h40 || pend !== 1'b0) $display("FAIL flush_vs_branch got pc=%h pend=%b want 00000040 0", pc, pend); else passed++;
    step();
    total++; if (pc !== 32'h44) $display("FAIL flush_vs_branch_seq got %h want 00000044", pc); else passed++;
  endtask

  task automatic test_misalign();
    br = 1; br_t = 32'h203;
    step();
    br = 0;
    total++; if (pc !== 32'h200 || mis !== 1'b1) $display("FAIL misalign got pc=%h mis=%b want 00000200 1", pc, mis); else passed++;
    step();
    total++; if (pc !== 32'h204 || mis !== 1'b0) $display("FAIL misalign_pulse got pc=%h mis=%b want 00000204 0", pc, mis); else passed++;
  endtask

  task automatic test_reset_mid();
    stall = 1; br = 1; br_t = 32'h900;
    step();
    br = 0;
    total++; if (pend !== 1'b1) $display("FAIL rst_mid_setup got pend=%b want 1", pend); else passed++;
    rst = 1;
    step();
    total++; if (pc !== 32'h100 || ce !== 1'b0 || pend !== 1'b0) $display("FAIL rst_mid got pc=%h ce=%b pend=%b want 00000100 0 0", pc, ce, pend); else passed++;
    rst = 0; stall = 0;
    step(); step();
    total++; if (pc !== 32'h104 || pend !== 1'b0) $display("FAIL rst_mid_drop got pc=%h pend=%b want 00000104 0", pc, pend); else passed++;
  endtask

  task automatic test_wrap();
    rst = 1;
    step();
    rst = 0;
    step();
    total++; if (pc8 !== 8'hFC || ce8 !== 1'b1) $display("FAIL wrap_start got pc=%h ce=%b want fc 1", pc8, ce8); else passed++;
    step();
    total++; if (pc8 !== 8'h00 || mis8 !== 1'b0) $display("FAIL wrap got pc=%h mis=%b want 00 0", pc8, mis8); else passed++;
    br8 = 1; br8_t = 8'h13;
    step();
    br8 = 0;
    total++; if (pc8 !== 8'h10 || mis8 !== 1'b1) $display("FAIL wrap_misalign got pc=%h mis=%b want 10 1", pc8, mis8); else passed++;
    step();
    total++; if (pc8 !== 8'h14 || mis8 !== 1'b0) $display("FAIL wrap_misalign_pulse got pc=%h mis=%b want 14 0", pc8, mis8); else passed++;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_pending();
    test_flush();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator at the head of the fetch stage, next generation of the single-issue PC register. It produces the fetch address and chip-enable for instruction memory and advances sequentially by a configurable instruction size. It accepts two redirect sources: branch from decode, and flush from the exception/commit path. A one-entry pending-redirect buffer ensures a branch that arrives while fetch is stalled or back-pressured is never lost. Everything runs on the rising edge of a single clock.

## Interface
- ADDR_W, 32: width of PC and target addresses.
- RESET_VEC, 32'h0000_0000: PC value held during reset and fetched first.
- INST_BYTES, 4: sequential increment; power of two, ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  pipeline stall for the PC stage (stall bit 0 of the hazard unit).
- fetch_ready_i  in  1  instruction memory accepts the current address this cycle.
- branch_valid_i  in  1  decode requests a redirect.
- branch_target_i  in  ADDR_W  branch target address.
- flush_valid_i  in  1  exception/flush redirect; highest priority.
- flush_target_i  in  ADDR_W  flush/handler address.
- pc_o  out  ADDR_W  current fetch address (registered).
- ce_o  out  1  instruction-memory enable (registered).
- fetch_valid_o  out  1  pc_o is a valid request; equals ce_o.
- pend_o  out  1  a branch redirect is buffered, not yet applied.
- misalign_o  out  1  one-cycle pulse: an applied target had nonzero bits below log2(INST_BYTES).

## Operation
- States: RESET (rst high), RUN. RESET→RUN on first clock with rst low; any state→RESET when rst is high.
- In RESET: pc_o=RESET_VEC, ce_o=0, pend_o=0, misalign_o=0. The pending buffer is cleared.
- Advance condition: adv = ce_o & ~stall_i & fetch_ready_i.
- Next-PC priority, evaluated every cycle in RUN:
  1. flush_valid_i: pc←flush_target_i. Applied regardless of stall_i or fetch_ready_i. The pending buffer is cleared.
  2. adv and pending buffer valid: pc←pending target; the buffer is cleared.
  3. adv and branch_valid_i: pc←branch_target_i.
  4. adv: pc←pc+INST_BYTES, modulo 2^ADDR_W (wraps to 0, no flag).
  5. Otherwise pc holds.
- Pending capture: branch_valid_i when not adv and no flush → the buffer loads branch_target_i, and pend_o=1 next cycle. A new branch while the buffer is already valid overwrites it, because the latest request wins.
- Branch together with adv while the buffer is valid: the buffer target is applied and the new branch is loaded into the buffer.
- Applied targets (flush, pending, or branch) have their low log2(INST_BYTES) bits forced to zero. If any of those bits were set, misalign_o=1 for the cycle after application.

## Timing
- Redirects take effect one cycle after sampling: target visible on pc_o the cycle after flush_valid_i or qualifying branch_valid_i.
- First valid fetch: the cycle after rst falls, ce_o=1 with pc_o=RESET_VEC; the first increment happens at the following adv.
- A buffered branch is applied on the first adv cycle after capture, with the same one-cycle latency.
- rst asserted mid-operation: the next edge forces the RESET values and discards the pending branch.
- Simultaneous flush and branch: the flush wins and the branch is dropped, not buffered.

## Structure
- Package pc_gen_pkg: state enum (RESET, RUN) and a redirect-source enum (NONE, FLUSH, PEND, BRANCH) used by the next-PC mux, for debug visibility.
- Sub-module pc_redirect_buf: one-entry valid+target register with load, clear, and consume controls; it is reused by the future BTB-driven fetch path.
- Top level: state register, priority mux, alignment mask/check, and incrementer.

## Test plan
- Reset release, RESET_VEC=0x100, ready=1, no stall: pc_o sequence 0x100, 0x104, 0x108; ce_o is 0 during rst and 1 from the first cycle after.
- Branch to 0x200 asserted at pc 0x108 with stall_i=0: next pc_o=0x200, then 0x204.
- Branch to 0x300 while stall_i=1 for 3 cycles: pend_o=1 and pc holds; first cycle after stall drops, pc_o=0x300 and pend_o=0.
- Flush to 0x80 while stall_i=1, fetch_ready_i=0, and a pending branch exists: next pc_o=0x80 and pend_o=0; the pending target is never fetched.
- ADDR_W=8, pc 0xFC, INST_BYTES=4, adv: pc_o=0x00 with no error; branch target 0x13 gives pc_o=0x10 and a one-cycle misalign_o pulse.
- rst asserted while pend_o=1: next cycle pc_o=RESET_VEC, ce_o=0, pend_o=0.
